// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES-128/192/256 encryption round sequencer.
// Issues one-hot key/add/sub/shift/mix step requests to the datapath,
// each held until i_ack, skipping mix-columns in the final round.
// Ports: clk, reset (sync, active-high); start/key_len launch a block;
// abort cancels it; i_ack completes the current step. Outputs: step
// requests, round_cnt, o_last_round, o_busy, o_finished and o_error.
module aes_round_ctrl #(
    parameter int         CNT_W       = 4,
    parameter logic [1:0] DEFAULT_LEN = 2'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       key_len,
    input  logic             abort,
    input  logic             i_ack,
    output logic             o_calc_key,
    output logic             o_add,
    output logic             o_substitute,
    output logic             o_shift_rows,
    output logic             o_mix_columns,
    output logic [CNT_W-1:0] round_cnt,
    output logic             o_last_round,
    output logic             o_busy,
    output logic             o_finished,
    output logic             o_error
);

    typedef enum logic [2:0] {
        IDLE, KEY, ADD, SUB, SHIFT, MIX, DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       len_q, len_d;
    logic             err_d;
    logic [CNT_W-1:0] nr_q, nr_d;
    logic             step_d;

    logic key_q, add_q, sub_q, shift_q, mix_q;
    logic last_q, busy_q, fin_q, err_q;

    function automatic logic [CNT_W-1:0] nr_of(input logic [1:0] len);
        case (len)
            2'd1:    nr_of = CNT_W'(12);
            2'd2:    nr_of = CNT_W'(14);
            default: nr_of = CNT_W'(10);
        endcase
    endfunction

    assign nr_q = nr_of(len_q);
    assign nr_d = nr_of(len_d);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        err_d   = 1'b0;
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (key_len == 2'd3) begin
                            err_d = 1'b1;
                        end else begin
                            len_d   = key_len;
                            cnt_d   = '0;
                            state_d = KEY;
                        end
                    end
                end
                KEY: if (i_ack) state_d = ADD;
                ADD: begin
                    if (i_ack) begin
                        if (cnt_q == nr_q) begin
                            state_d = DONE;
                        end else begin
                            cnt_d   = cnt_q + CNT_W'(1);
                            state_d = SUB;
                        end
                    end
                end
                SUB: if (i_ack) state_d = SHIFT;
                SHIFT: begin
                    // Final round has no mix-columns step.
                    if (i_ack) state_d = (cnt_q == nr_q) ? KEY : MIX;
                end
                MIX: if (i_ack) state_d = KEY;
                DONE: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign step_d = (state_d != IDLE) && (state_d != DONE);

    // Outputs are registered from the next state so they line up
    // exactly with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= DEFAULT_LEN;
            key_q   <= 1'b0;
            add_q   <= 1'b0;
            sub_q   <= 1'b0;
            shift_q <= 1'b0;
            mix_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            key_q   <= (state_d == KEY);
            add_q   <= (state_d == ADD);
            sub_q   <= (state_d == SUB);
            shift_q <= (state_d == SHIFT);
            mix_q   <= (state_d == MIX);
            last_q  <= step_d && (cnt_d == nr_d);
            busy_q  <= (state_d != IDLE);
            fin_q   <= (state_d == DONE);
            err_q   <= err_d;
        end
    end

    assign o_calc_key    = key_q;
    assign o_add         = add_q;
    assign o_substitute  = sub_q;
    assign o_shift_rows  = shift_q;
    assign o_mix_columns = mix_q;
    assign round_cnt     = cnt_q;
    assign o_last_round  = last_q;
    assign o_busy        = busy_q;
    assign o_finished    = fin_q;
    assign o_error       = err_q;

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Parametrised AES encryption round controller. It succeeds the fixed 128-bit encryption FSM and supports AES-128/192/256, selected per block at start. It sits between the main load/process/send FSM and the datapath units (key expansion, S-box substitution, shift-rows, mix-columns, add-round-key). Each datapath step is sequenced by a request/acknowledge handshake, and the block also handles final-round mix-column skipping, abort and illegal-mode rejection.

## Interface
- `CNT_W`, default 4: round counter width. Must hold 14.
- `DEFAULT_LEN`, default 0: reset value of the latched key length (0=128, 1=192, 2=256).
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin encryption of one block; sampled only in IDLE.
- `key_len`  in  2  key size: 0=128, 1=192, 2=256, 3=illegal. Sampled with `start`.
- `abort`  in  1  cancel the current block; return to IDLE.
- `i_ack`  in  1  the datapath completed the currently requested step.
- `o_calc_key`  out  1  request key expansion for round `round_cnt`.
- `o_add`  out  1  request add-round-key.
- `o_substitute`  out  1  request byte substitution.
- `o_shift_rows`  out  1  request shift-rows.
- `o_mix_columns`  out  1  request mix-columns.
- `round_cnt`  out  CNT_W  current round: 0 for the initial key round, then 1..Nr.
- `o_last_round`  out  1  high while `round_cnt == Nr`.
- `o_busy`  out  1  high in every state except IDLE.
- `o_finished`  out  1  one-cycle pulse when the block completes.
- `o_error`  out  1  one-cycle pulse when `start` arrives with `key_len == 3`.

## Operation
- Nr is decoded from the latched key length: 128→10, 192→12, 256→14. The key length is latched only on an accepted `start`.
- States: IDLE, KEY, ADD, SUB, SHIFT, MIX, DONE.
- IDLE
  - `start` with a legal `key_len`: set `round_cnt` = 0, go to KEY.
  - `start` with `key_len == 3`: pulse `o_error`, stay in IDLE.
- KEY → ADD on `i_ack`.
- ADD on `i_ack`:
  - if `round_cnt == Nr`, go to DONE;
  - otherwise increment `round_cnt` and go to SUB.
- SUB → SHIFT on `i_ack`.
- SHIFT on `i_ack`:
  - final round (`round_cnt == Nr`) goes to KEY, skipping MIX;
  - otherwise go to MIX.
- MIX → KEY on `i_ack`.
- DONE: pulse `o_finished`, go to IDLE.
- Step requests are one-hot and decoded from the state register (Moore):
  - exactly one of `o_calc_key`, `o_add`, `o_substitute`, `o_shift_rows`, `o_mix_columns` is high in KEY/ADD/SUB/SHIFT/MIX;
  - all are low in IDLE and DONE.
- A request stays high until `i_ack` is sampled high at a rising edge. `i_ack` in IDLE or DONE is ignored.
- `abort` is honoured in any non-IDLE state. On the next edge: go to IDLE, clear `round_cnt`, drop all requests, no `o_finished`. `abort` has priority over `i_ack` in the same cycle.
- `start` while busy is ignored; `key_len` changes while busy have no effect.
- `round_cnt` never exceeds Nr and never wraps.

## Timing
- Reset values:
  - state IDLE, `round_cnt` = 0, latched length = `DEFAULT_LEN`;
  - all request outputs 0; `o_last_round`, `o_busy`, `o_finished`, `o_error` all 0.
- `start` accepted at edge N → `o_calc_key` and `o_busy` high from cycle N+1.
- `i_ack` high at edge M → the next request is high in cycle M+1. There is no bubble between steps.
- Step visits per block: 2 + 5·(Nr−1) + 4.
- With `i_ack` held high (latency counted from the start edge N):
  - AES-128: 51 step cycles, `o_finished` in cycle N+52;
  - AES-192: 61 step cycles, `o_finished` in cycle N+62;
  - AES-256: 71 step cycles, `o_finished` in cycle N+72.
- `o_busy` is high through DONE and low the cycle after.
- A new `start` can be accepted in the cycle after DONE.
- `o_error` is high in cycle N+1 for an illegal `start` at edge N.
- `reset` mid-block has the same effect as `abort` and also restores `DEFAULT_LEN`.

## Test plan
- AES-128, `i_ack` tied high, `start` at edge 0:
  - request sequence is KEY, ADD, then 9×(SUB, SHIFT, MIX, KEY, ADD), then SUB, SHIFT, KEY, ADD;
  - `o_finished` in cycle 52;
  - `o_mix_columns` never high while `round_cnt == 10`.
- AES-192 and AES-256 with `i_ack` tied high:
  - `o_finished` in cycles 62 and 72 respectively;
  - `round_cnt` maximum is 12 and 14 respectively;
  - `o_last_round` is high for exactly 4 cycles.
- AES-128 with random `i_ack` delays of 0–5 cycles:
  - each request is held until acknowledged and only one request is ever high;
  - the total number of request-cycles equals the sum of the delays plus 51.
- `start` with `key_len = 3` → `o_error` = 1 for one cycle, `o_busy` stays 0. A subsequent legal `start` proceeds normally.
- `abort` asserted together with `i_ack` in round 5 SHIFT → IDLE on the next edge, `round_cnt` = 0, no `o_finished`. A new 256-bit block then completes with `o_finished` in cycle N+72.
- `reset` asserted mid-round 3 → all outputs return to their reset values on the next edge. `start` while busy produces no restart and no change of Nr.
